// File: rtl/mux2x1_pkg.sv
// Shared constants for the mux2x1 slice: default widths and the counter saturation limit.
// Used by the top, its interface and the optional transition counter (MUX2X1_SEL_CNT_EN).
package mux2x1_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_CNT_W = 8;

    // Saturation limit of the default-width transition counter.
    localparam int SAT_MAX = (1 << DEFAULT_CNT_W) - 1;

    // All-ones value for an arbitrary counter width (valid up to 31 bits).
    function automatic logic [31:0] sat_max(input int cnt_w);
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

endpackage : mux2x1_pkg

// File: rtl/mux2x1_if.sv
// Bus bundle for mux2x1: switch-side inputs A/B/S and the LED-side outputs.
// sel_changes only carries live data when MUX2X1_SEL_CNT_EN is defined.
interface mux2x1_if
    import mux2x1_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
);

    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             S;
    logic [WIDTH-1:0] F;
    logic [WIDTH-1:0] F_q;
    logic             S_q;
    logic [CNT_W-1:0] sel_changes;

    modport master (
        output A,
        output B,
        output S,
        input  F,
        input  F_q,
        input  S_q,
        input  sel_changes
    );

    modport slave (
        input  A,
        input  B,
        input  S,
        output F,
        output F_q,
        output S_q,
        output sel_changes
    );

endinterface : mux2x1_if

// File: rtl/mux2x1_sat_cnt.sv
// Saturating count of select-line transitions, enabled one edge after reset release.
// Only instantiated by mux2x1 when MUX2X1_SEL_CNT_EN is defined.
module mux2x1_sat_cnt
    import mux2x1_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_sel,
    input  logic             i_sel_q,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

    logic             r_primed;
    logic [CNT_W-1:0] r_count;
    logic             w_toggle;
    logic             w_at_max;

    // i_sel_q is the select sampled at the previous edge, so this compares sampled values only.
    assign w_toggle = r_primed && (i_sel != i_sel_q);
    assign w_at_max = (r_count == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_primed <= 1'b0;
            r_count  <= '0;
        end else begin
            r_primed <= 1'b1;
            if (w_toggle && !w_at_max) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_count = r_count;

endmodule : mux2x1_sat_cnt

// File: rtl/mux2x1.sv
// Two-input word mux with combinational F, registered F_q/S_q and an optional
// saturating select-transition counter compiled in by MUX2X1_SEL_CNT_EN.
module mux2x1
    import mux2x1_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input logic     clk,
    input logic     rst_n,
    mux2x1_if.slave bus
);

    logic [WIDTH-1:0] w_f;
    logic [WIDTH-1:0] r_f_q;
    logic             r_s_q;
    logic [CNT_W-1:0] w_sel_changes;

    // An unknown select propagates as all-X rather than merging A and B.
    always_comb begin
        w_f = 'x;
        case (bus.S)
            1'b0:    w_f = bus.A;
            1'b1:    w_f = bus.B;
            default: w_f = 'x;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_f_q <= '0;
            r_s_q <= 1'b0;
        end else begin
            r_f_q <= w_f;
            r_s_q <= bus.S;
        end
    end

`ifdef MUX2X1_SEL_CNT_EN
    mux2x1_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_sat_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_sel   (bus.S),
        .i_sel_q (r_s_q),
        .o_count (w_sel_changes)
    );
`else
    assign w_sel_changes = '0;
`endif

    assign bus.F           = w_f;
    assign bus.F_q         = r_f_q;
    assign bus.S_q         = r_s_q;
    assign bus.sel_changes = w_sel_changes;

endmodule : mux2x1

// File: tb/tb_mux2x1.sv
// Scoreboard bench for mux2x1: an 8-bit-counter DUT and a 2-bit-counter DUT share stimulus.
// Expected counts follow MUX2X1_SEL_CNT_EN (zero when the counter is compiled out).
module tb_mux2x1;

    logic clk;
    logic rst_n;

    mux2x1_if #(.WIDTH(4), .CNT_W(8)) bus ();
    mux2x1_if #(.WIDTH(4), .CNT_W(2)) bus2 ();

    mux2x1 #(.WIDTH(4), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    mux2x1 #(.WIDTH(4), .CNT_W(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] fq;
        logic       sq;
        logic [7:0] cnt;
        logic [1:0] cnt2;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] m_fq;
    logic       m_sq;
    logic [7:0] m_cnt;
    logic [1:0] m_cnt2;
    logic       m_primed;
    logic [3:0] exp_f;

    // Drive one cycle of stimulus, advance the reference model and queue its result.
    task automatic step(input logic [3:0] a, input logic [3:0] b, input logic s,
                        input logic rn, input logic glitch);
        exp_t e;
        bus.A = a;  bus.B = b;  bus.S = s;
        bus2.A = a; bus2.B = b; bus2.S = s;
        rst_n = rn;
        if (glitch) begin
            #1; bus.S = ~s; bus2.S = ~s;
            #1; bus.S = s;  bus2.S = s;
        end
        #1;
        exp_f = s ? b : a;
        if (!rn) begin
            m_fq = '0; m_sq = 1'b0; m_cnt = '0; m_cnt2 = '0; m_primed = 1'b0;
        end else begin
            if (m_primed && (s != m_sq)) begin
                if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
                if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
            end
            m_fq = s ? b : a;
            m_sq = s;
            m_primed = 1'b1;
        end
        e.fq = m_fq;
        e.sq = m_sq;
`ifdef MUX2X1_SEL_CNT_EN
        e.cnt  = m_cnt;
        e.cnt2 = m_cnt2;
`else
        e.cnt  = '0;
        e.cnt2 = '0;
`endif
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            step(4'hF, 4'hF, 1'b1, (i == 2), 1'b0);
            n_cmp++;
            if (bus.F !== exp_f) begin
                n_err++; $display("FAIL reset_F cyc%0d got %h want %h", i, bus.F, exp_f);
            end
            @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++;
            if (bus.F_q !== e.fq) begin
                n_err++; $display("FAIL reset_Fq cyc%0d got %h want %h", i, bus.F_q, e.fq);
            end
            n_cmp++;
            if (bus.S_q !== e.sq) begin
                n_err++; $display("FAIL reset_Sq cyc%0d got %b want %b", i, bus.S_q, e.sq);
            end
            n_cmp++;
            if (bus.sel_changes !== e.cnt || bus2.sel_changes !== e.cnt2) begin
                n_err++; $display("FAIL reset_cnt cyc%0d got %0d/%0d want %0d/%0d", i,
                                  bus.sel_changes, bus2.sel_changes, e.cnt, e.cnt2);
            end
            $display("reset cyc%0d rst_n=%b F=%h F_q=%h S_q=%b cnt=%0d", i, rst_n, bus.F,
                     bus.F_q, bus.S_q, bus.sel_changes);
        end
    endtask

    task automatic test_basic();
        logic [8:0] tbl [6];
        exp_t e;
        tbl = '{ {4'h0, 4'hF, 1'b0}, {4'h0, 4'hF, 1'b0}, {4'h0, 4'hF, 1'b1},
                 {4'h9, 4'h6, 1'b0}, {4'h9, 4'h6, 1'b1}, {4'h9, 4'h6, 1'b1} };
        for (int i = 0; i < 6; i++) begin
            step(tbl[i][8:5], tbl[i][4:1], tbl[i][0], 1'b1, 1'b0);
            n_cmp++;
            if (bus.F !== exp_f) begin
                n_err++; $display("FAIL basic_F row%0d got %h want %h", i, bus.F, exp_f);
            end
            @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++;
            if (bus.F_q !== e.fq || bus.S_q !== e.sq) begin
                n_err++; $display("FAIL basic_reg row%0d got %h/%b want %h/%b", i,
                                  bus.F_q, bus.S_q, e.fq, e.sq);
            end
            n_cmp++;
            if (bus.sel_changes !== e.cnt) begin
                n_err++; $display("FAIL basic_cnt row%0d got %0d want %0d", i,
                                  bus.sel_changes, e.cnt);
            end
            $display("basic row%0d S=%b F=%h F_q=%h cnt=%0d", i, bus.S, bus.F, bus.F_q,
                     bus.sel_changes);
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        logic s;
        s = bus.S;
        for (int i = 0; i < 6; i++) begin
            s = ~s;
            step(4'h3, 4'hC, s, 1'b1, 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++;
            if (bus2.sel_changes !== e.cnt2 || bus.sel_changes !== e.cnt) begin
                n_err++; $display("FAIL sat_cnt cyc%0d got %0d/%0d want %0d/%0d", i,
                                  bus.sel_changes, bus2.sel_changes, e.cnt, e.cnt2);
            end
            $display("sat cyc%0d S=%b cnt8=%0d cnt2=%0d", i, bus.S, bus.sel_changes,
                     bus2.sel_changes);
        end
        n_cmp++;
`ifdef MUX2X1_SEL_CNT_EN
        if (bus2.sel_changes !== 2'd3) begin
            n_err++; $display("FAIL sat_hold got %0d want 3", bus2.sel_changes);
        end
`else
        if (bus2.sel_changes !== 2'd0) begin
            n_err++; $display("FAIL sat_hold got %0d want 0", bus2.sel_changes);
        end
`endif
    endtask

    task automatic test_midreset();
        exp_t e;
        // Two reset edges mid-run, then release with S low, then a counted toggle.
        for (int i = 0; i < 4; i++) begin
            step(4'hF, 4'hF, (i < 2) || (i == 3), (i >= 2), 1'b0);
            n_cmp++;
            if (bus.F !== exp_f) begin
                n_err++; $display("FAIL midrst_F cyc%0d got %h want %h", i, bus.F, exp_f);
            end
            @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++;
            if (bus.F_q !== e.fq || bus.S_q !== e.sq) begin
                n_err++; $display("FAIL midrst_reg cyc%0d got %h/%b want %h/%b", i,
                                  bus.F_q, bus.S_q, e.fq, e.sq);
            end
            n_cmp++;
            if (bus.sel_changes !== e.cnt || bus2.sel_changes !== e.cnt2) begin
                n_err++; $display("FAIL midrst_cnt cyc%0d got %0d/%0d want %0d/%0d", i,
                                  bus.sel_changes, bus2.sel_changes, e.cnt, e.cnt2);
            end
            $display("midrst cyc%0d rst_n=%b F_q=%h S_q=%b cnt=%0d", i, rst_n, bus.F_q,
                     bus.S_q, bus.sel_changes);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [3:0] a, b;
        logic       s, g;
        for (int i = 0; i < 24; i++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            s = 1'($urandom_range(0, 1));
            g = 1'($urandom_range(0, 1));
            step(a, b, s, 1'b1, g);
            n_cmp++;
            if (bus.F !== exp_f) begin
                n_err++; $display("FAIL b2b_F cyc%0d got %h want %h", i, bus.F, exp_f);
            end
            @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++;
            if (bus.F_q !== e.fq || bus.S_q !== e.sq) begin
                n_err++; $display("FAIL b2b_reg cyc%0d got %h/%b want %h/%b", i,
                                  bus.F_q, bus.S_q, e.fq, e.sq);
            end
            n_cmp++;
            if (bus.sel_changes !== e.cnt || bus2.sel_changes !== e.cnt2) begin
                n_err++; $display("FAIL b2b_cnt cyc%0d got %0d/%0d want %0d/%0d", i,
                                  bus.sel_changes, bus2.sel_changes, e.cnt, e.cnt2);
            end
            $display("b2b cyc%0d A=%h B=%h S=%b glitch=%b F_q=%h cnt=%0d", i, a, b, s, g,
                     bus.F_q, bus.sel_changes);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.A = '0;  bus.B = '0;  bus.S = 1'b0;
        bus2.A = '0; bus2.B = '0; bus2.S = 1'b0;
        m_fq = '0; m_sq = 1'b0; m_cnt = '0; m_cnt2 = '0; m_primed = 1'b0;
        exp_f = '0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_saturation();
        test_midreset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mux2x1
